// File: rtl/ecc_secded_decode_pipe.sv
// Two-stage SECDED (extended Hamming) decoder for the RAM read path.
// Stage 1 computes syndrome/parity, stage 2 corrects, classifies and counts.
module ecc_secded_decode_pipe #(
  parameter int P_DATAWIDTH       = 32,
  parameter int P_CHECKBITS_COUNT = 7,
  parameter int P_CODEWIDTH       = 39,
  parameter int P_ADDRWIDTH       = 10,
  parameter int P_CNTWIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [P_CODEWIDTH-1:0]       code_in,
  input  logic [P_ADDRWIDTH-1:0]       addr_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [P_DATAWIDTH-1:0]       data_out,
  output logic [P_ADDRWIDTH-1:0]       addr_out,
  output logic                         single_error,
  output logic                         double_error,
  output logic [P_CNTWIDTH-1:0]        corr_count,
  output logic [P_CNTWIDTH-1:0]        uncorr_count,
  output logic                         err_valid,
  output logic [P_ADDRWIDTH-1:0]       err_addr,
  output logic [P_CHECKBITS_COUNT-1:0] err_syndrome,
  input  logic                         clr
);

  localparam int PB = P_CHECKBITS_COUNT - 1;

  if (P_DATAWIDTH < 4 || P_DATAWIDTH > 64) begin : g_bad_dw
    $error("P_DATAWIDTH out of range");
  end
  if ((2**PB) < P_DATAWIDTH + PB + 1 ||
      (2**(PB-1)) >= P_DATAWIDTH + PB) begin : g_bad_cb
    $error("P_CHECKBITS_COUNT is not minimal");
  end
  if (P_CODEWIDTH != P_DATAWIDTH + P_CHECKBITS_COUNT) begin : g_bad_cw
    $error("P_CODEWIDTH mismatch");
  end

  // Code index (0-based) that carries data bit i.
  function automatic int data_pos(input int i);
    int n;
    n = 0;
    data_pos = 0;
    for (int p = 1; p < P_CODEWIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) data_pos = p - 1;
        n++;
      end
    end
  endfunction

  logic [PB-1:0]          syn_in;
  logic                   mism_in;
  logic [P_DATAWIDTH-1:0] raw_in;

  always_comb begin
    syn_in = '0;
    for (int j = 0; j < P_CODEWIDTH - 1; j++) begin
      if (code_in[j]) syn_in = syn_in ^ PB'(j + 1);
    end
    mism_in = ^code_in;
  end

  for (genvar i = 0; i < P_DATAWIDTH; i++) begin : g_raw
    assign raw_in[i] = code_in[data_pos(i)];
  end

  logic                   s1_valid;
  logic [P_DATAWIDTH-1:0] s1_data;
  logic [P_ADDRWIDTH-1:0] s1_addr;
  logic [PB-1:0]          s1_syn;
  logic                   s1_mism;
  logic [PB:0]            s2_syn;

  logic s1_load;
  logic s2_load;
  logic fire;

  assign s2_load  = !out_valid | out_ready;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = s1_load;
  assign fire     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_addr  <= '0;
      s1_syn   <= '0;
      s1_mism  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= raw_in;
        s1_addr <= addr_in;
        s1_syn  <= syn_in;
        s1_mism <= mism_in;
      end
    end
  end

  logic                   nz;
  logic                   in_range;
  logic                   corr_en;
  logic                   dbl;
  logic [P_DATAWIDTH-1:0] fixed;

  assign nz       = s1_syn != '0;
  assign in_range = s1_syn <= PB'(P_CODEWIDTH - 1);
  assign corr_en  = nz & s1_mism & in_range;
  // M=1 always reports a single; out-of-range syndromes add the double flag.
  assign dbl      = (nz & !s1_mism) | (nz & s1_mism & !in_range);

  for (genvar i = 0; i < P_DATAWIDTH; i++) begin : g_fix
    assign fixed[i] = s1_data[i] ^
                      (corr_en && s1_syn == PB'(data_pos(i) + 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      data_out     <= '0;
      addr_out     <= '0;
      single_error <= 1'b0;
      double_error <= 1'b0;
      s2_syn       <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out     <= fixed;
        addr_out     <= s1_addr;
        single_error <= s1_mism;
        double_error <= dbl;
        s2_syn       <= {s1_mism, s1_syn};
      end
    end
  end

  logic [P_CNTWIDTH-1:0] corr_base;
  logic [P_CNTWIDTH-1:0] corr_next;
  logic [P_CNTWIDTH-1:0] uncorr_base;
  logic [P_CNTWIDTH-1:0] uncorr_next;
  logic                  ev_base;
  logic                  cap;

  // clr acts first so a coincident event lands on the cleared state.
  always_comb begin
    corr_base   = clr ? '0 : corr_count;
    uncorr_base = clr ? '0 : uncorr_count;
    ev_base     = clr ? 1'b0 : err_valid;
    corr_next   = corr_base;
    uncorr_next = uncorr_base;
    if (fire && single_error && !double_error && corr_base != '1)
      corr_next = corr_base + P_CNTWIDTH'(1);
    if (fire && double_error && uncorr_base != '1)
      uncorr_next = uncorr_base + P_CNTWIDTH'(1);
    cap = fire & (single_error | double_error) & !ev_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count   <= '0;
      uncorr_count <= '0;
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_syndrome <= '0;
    end else begin
      corr_count   <= corr_next;
      uncorr_count <= uncorr_next;
      err_valid    <= ev_base | cap;
      if (cap) begin
        err_addr     <= addr_out;
        err_syndrome <= s2_syn;
      end
    end
  end

endmodule

// File: tb/tb_ecc_secded_decode_pipe.sv
// Directed bench for ecc_secded_decode_pipe: vector table plus
// backpressure, saturation, clear and async reset sequences.
module tb_ecc_secded_decode_pipe;

  localparam int DW = 32;
  localparam int CB = 7;
  localparam int CW = 39;
  localparam int AW = 10;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] code_in;
  logic [AW-1:0] addr_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_out;
  logic          single_error;
  logic          double_error;
  logic [NW-1:0] corr_count;
  logic [NW-1:0] uncorr_count;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [CB-1:0] err_syndrome;
  logic          clr;

  int n_checks = 0;
  int n_fail   = 0;

  ecc_secded_decode_pipe #(
    .P_DATAWIDTH(DW), .P_CHECKBITS_COUNT(CB), .P_CODEWIDTH(CW),
    .P_ADDRWIDTH(AW), .P_CNTWIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .addr_out(addr_out),
    .single_error(single_error), .double_error(double_error),
    .corr_count(corr_count), .uncorr_count(uncorr_count),
    .err_valid(err_valid), .err_addr(err_addr),
    .err_syndrome(err_syndrome), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoder: data into non power-of-two positions, then
  // check bits chosen so the syndrome is zero, then overall parity.
  function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    logic [CB-2:0] s;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < CW; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    s = '0;
    for (int p = 1; p < CW; p++) if (c[p-1]) s = s ^ (CB-1)'(p);
    for (int i = 0; i < CB - 1; i++) c[(1 << i) - 1] = s[i];
    c[CW-1] = ^c[CW-2:0];
    return c;
  endfunction

  function automatic logic [DW-1:0] dat(input int i);
    return 32'hA5A5_0000 + DW'(i) * 32'h0000_0101;
  endfunction

  typedef struct {
    logic [CW-1:0] code;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    flags;
    logic [NW-1:0] corr;
    logic [NW-1:0] uncorr;
    logic          ev;
    logic [AW-1:0] eaddr;
    logic [CB-1:0] esyn;
  } vec_t;

  vec_t tbl[9];

  task automatic run_stream(input int n, input int tag0,
                            input logic [CW-1:0] mask);
    int sent;
    int got;
    sent = 0;
    got  = 0;
    for (int c = 0; c < n + 20 && got < n; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = sent < n;
      code_in   = enc(dat(sent)) ^ mask;
      addr_in   = AW'(tag0 + sent);
      #1;
      if (out_valid) begin
        chk("stream_data", 64'(data_out), 64'(dat(got)));
        chk("stream_addr", 64'(addr_out), 64'(tag0 + got));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CW-1:0] base;
    logic [DW-1:0] held_d;
    logic [AW-1:0] held_a;
    logic          stalled;
    int sent;
    int got;

    base = enc(32'hDEADBEEF);
    tbl[0] = '{base, 10'd5, 32'hDEADBEEF, 2'b00, 4'd0, 4'd0,
               1'b0, 10'd0, 7'h00};
    tbl[1] = '{base ^ (CW'(1) << 2), 10'd5, 32'hDEADBEEF, 2'b10,
               4'd1, 4'd0, 1'b1, 10'd5, 7'h43};
    tbl[2] = '{base ^ (CW'(1) << 38), 10'd6, 32'hDEADBEEF, 2'b10,
               4'd2, 4'd0, 1'b1, 10'd5, 7'h43};
    tbl[3] = '{base ^ (CW'(1) << 4) ^ (CW'(1) << 9), 10'd7,
               32'hDEADBEEF ^ 32'h22, 2'b01, 4'd2, 4'd1,
               1'b1, 10'd5, 7'h43};
    tbl[4] = '{base ^ CW'(39'h0B), 10'd8, 32'hDEADBEEF ^ 32'h8,
               2'b10, 4'd3, 4'd1, 1'b1, 10'd5, 7'h43};
    tbl[5] = '{base ^ (CW'(1) << 31) ^ (CW'(1) << 15) ^ (CW'(1) << 23),
               10'd9, 32'hDEADBEEF ^ 32'h0004_0000, 2'b11,
               4'd3, 4'd2, 1'b1, 10'd5, 7'h43};
    tbl[6] = '{enc(32'h12345678), 10'd10, 32'h12345678, 2'b00,
               4'd3, 4'd2, 1'b1, 10'd5, 7'h43};
    tbl[7] = '{enc(32'h0), 10'd0, 32'h0, 2'b00,
               4'd3, 4'd2, 1'b1, 10'd5, 7'h43};
    tbl[8] = '{enc(32'hFFFFFFFF) ^ (CW'(1) << 20), 10'h3FF,
               32'hFFFFFFFF, 2'b10, 4'd4, 4'd2, 1'b1, 10'd5, 7'h43};

    rst = 1'b1;
    in_valid = 1'b0;
    code_in = '0;
    addr_in = '0;
    out_ready = 1'b1;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_corr", 64'(corr_count), 64'd0);
    chk("rst_uncorr", 64'(uncorr_count), 64'd0);
    chk("rst_err_valid", 64'(err_valid), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      code_in  = tbl[i].code;
      addr_in  = tbl[i].addr;
      @(negedge clk);
      in_valid = 1'b0;
      chk("vec_lat1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("vec_lat2_valid", 64'(out_valid), 64'd1);
      chk("vec_data", 64'(data_out), 64'(tbl[i].data));
      chk("vec_addr", 64'(addr_out), 64'(tbl[i].addr));
      chk("vec_flags", 64'({single_error, double_error}),
          64'(tbl[i].flags));
      @(negedge clk);
      chk("vec_corr", 64'(corr_count), 64'(tbl[i].corr));
      chk("vec_uncorr", 64'(uncorr_count), 64'(tbl[i].uncorr));
      chk("vec_err_valid", 64'(err_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("vec_err_addr", 64'(err_addr), 64'(tbl[i].eaddr));
        chk("vec_err_syn", 64'(err_syndrome), 64'(tbl[i].esyn));
      end
    end

    // 8 back-to-back words, consumer stalls in cycles 3..6
    sent = 0;
    got = 0;
    stalled = 1'b0;
    held_d = '0;
    held_a = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = sent < 8;
      code_in   = enc(dat(sent));
      addr_in   = AW'(20 + sent);
      #1;
      if (c == 3) chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
      if (c == 7) chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
      if (out_valid) begin
        if (stalled) begin
          chk("bp_hold_data", 64'(data_out), 64'(held_d));
          chk("bp_hold_addr", 64'(addr_out), 64'(held_a));
        end
        if (out_ready) begin
          chk("bp_data", 64'(data_out), 64'(dat(got)));
          chk("bp_addr", 64'(addr_out), 64'(20 + got));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d = data_out;
          held_a = addr_out;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_received", 64'(got), 64'd8);
    chk("bp_sent", 64'(sent), 64'd8);
    repeat (2) @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_corr_same", 64'(corr_count), 64'd4);

    // clear, then drive the corrected counter into saturation
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_corr", 64'(corr_count), 64'd0);
    chk("clr_uncorr", 64'(uncorr_count), 64'd0);
    chk("clr_err_valid", 64'(err_valid), 64'd0);
    run_stream(14, 100, CW'(1) << 2);
    chk("sat_pre", 64'(corr_count), 64'hE);
    chk("sat_err_addr", 64'(err_addr), 64'd100);
    chk("sat_err_syn", 64'(err_syndrome), 64'h43);
    run_stream(3, 200, CW'(1) << 2);
    chk("sat_full", 64'(corr_count), 64'hF);
    chk("sat_err_addr_kept", 64'(err_addr), 64'd100);
    chk("sat_uncorr", 64'(uncorr_count), 64'd0);

    // clr in the same cycle as a double-error handshake
    @(negedge clk);
    in_valid = 1'b1;
    code_in  = base ^ (CW'(1) << 4) ^ (CW'(1) << 9);
    addr_in  = 10'h55;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clrev_out_valid", 64'(out_valid), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clrev_uncorr", 64'(uncorr_count), 64'd1);
    chk("clrev_corr", 64'(corr_count), 64'd0);
    chk("clrev_err_valid", 64'(err_valid), 64'd1);
    chk("clrev_err_addr", 64'(err_addr), 64'h55);
    chk("clrev_err_syn", 64'(err_syndrome), 64'h0F);

    // async reset in the middle of a correctable stream
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      code_in  = enc(dat(c)) ^ (CW'(1) << 2);
      addr_in  = AW'(300 + c);
    end
    #2;
    chk("pre_rst_corr", 64'(corr_count != 0), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_corr", 64'(corr_count), 64'd0);
    chk("arst_uncorr", 64'(uncorr_count), 64'd0);
    chk("arst_err_valid", 64'(err_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("arst_flushed", 64'(out_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
